// File: rtl/pwm_sequencer.sv
// pwm_sequencer
//   Sequences an external up-counter to produce a PWM waveform.
//   The counter is cleared (cnt_clr) and enabled (cnt_en) from here.
//   The sequencer compares the counter's value against the active
//   period and duty settings.
//
//   A new period/duty pair is handed over with a valid/ready transfer into
//   a one-deep pending slot. The pending pair only becomes active while idle
//   or on a period boundary, so a running period is never altered midway.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-low reset
//   en           run request; dropping it stops at the next period boundary
//   count        current value of the external counter
//   cnt_en       counter enable
//   cnt_clr      counter synchronous clear (active high)
//   cfg_valid    new period/duty offered
//   cfg_ready    pending slot free, offer will be taken
//   cfg_period   terminal count (period = cfg_period + 1 cycles)
//   cfg_duty     high time in cycles
//   pwm_out      PWM waveform
//   period_done  high on the last cycle of every period
module pwm_sequencer #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   cnt_en,
    output logic                   cnt_clr,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_period,
    input  logic [COUNT_WIDTH-1:0] cfg_duty,
    output logic                   pwm_out,
    output logic                   period_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [COUNT_WIDTH-1:0] per_a_r;
    logic [COUNT_WIDTH-1:0] duty_a_r;
    logic [COUNT_WIDTH-1:0] per_p_r;
    logic [COUNT_WIDTH-1:0] duty_p_r;
    logic                   pend_r;
    logic                   cfg_loaded_r;
    logic                   boundary_s;
    logic                   xfer_s;
    logic                   load_s;

    // The slot is free whenever nothing is pending; pend_r is a register,
    // so cfg_ready carries no combinational path from the inputs.
    assign cfg_ready = !pend_r;
    assign xfer_s    = cfg_valid && !pend_r;
    // Pending moves to active while idle or exactly on a period boundary.
    assign load_s    = pend_r && ((state_r == IDLE) || boundary_s);

    // Next-state and output decode. Outputs depend only on state, count and
    // registered config, so a reset drops them within the same cycle.
    always_comb begin
        state_s     = state_r;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b1;
        pwm_out     = 1'b0;
        period_done = 1'b0;
        boundary_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && cfg_loaded_r) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN, DRAIN: begin
                cnt_en = 1'b1;
                // A count above per_a (foreign counter state) is never a
                // boundary; the counter keeps running until it wraps.
                boundary_s  = (count == per_a_r);
                cnt_clr     = boundary_s;
                period_done = boundary_s;
                pwm_out     = (count < duty_a_r);
                if (boundary_s) begin
                    state_s = en ? RUN : IDLE;
                end else begin
                    state_s = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Active/pending configuration registers and their handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_a_r      <= '0;
            duty_a_r     <= '0;
            per_p_r      <= '0;
            duty_p_r     <= '0;
            pend_r       <= 1'b0;
            cfg_loaded_r <= 1'b0;
        end else begin
            // load_s needs pend_r=1 and xfer_s needs pend_r=0, so at most
            // one of the two branches is live in any cycle.
            if (load_s) begin
                per_a_r      <= per_p_r;
                duty_a_r     <= duty_p_r;
                pend_r       <= 1'b0;
                cfg_loaded_r <= 1'b1;
            end else if (xfer_s) begin
                per_p_r  <= cfg_period;
                duty_p_r <= cfg_duty;
                pend_r   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
module tb_pwm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] count;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       pwm_out;
    logic       period_done;

    int total = 0;
    int bad   = 0;

    // External counter stand-in, with an override to inject foreign values.
    logic [7:0] tb_count  = 8'd0;
    logic       force_on  = 1'b0;
    logic [7:0] force_val = 8'd0;
    assign count = force_on ? force_val : tb_count;

    pwm_sequencer #(.COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .count(count),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .pwm_out(pwm_out), .period_done(period_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr) tb_count <= 8'd0;
        else if (cnt_en) tb_count <= tb_count + 8'd1;
    end

    // Behavioural model: "generating" flag, active config, one pending slot.
    logic       m_gen  = 1'b0;
    logic       m_have = 1'b0;
    logic [7:0] m_per  = 8'd0;
    logic [7:0] m_duty = 8'd0;
    logic       mp_v   = 1'b0;
    logic [7:0] mp_per = 8'd0;
    logic [7:0] mp_duty = 8'd0;
    logic       m_bnd;
    logic       m_take;
    assign m_bnd  = m_gen && (count == m_per);
    assign m_take = mp_v && (!m_gen || m_bnd);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_gen <= 1'b0; m_have <= 1'b0; m_per <= 8'd0; m_duty <= 8'd0;
            mp_v <= 1'b0; mp_per <= 8'd0; mp_duty <= 8'd0;
        end else begin
            if (!m_gen) m_gen <= en && m_have;
            else if (m_bnd) m_gen <= en;
            if (m_take) begin
                m_per <= mp_per; m_duty <= mp_duty; m_have <= 1'b1; mp_v <= 1'b0;
            end else if (cfg_valid && !mp_v) begin
                mp_v <= 1'b1; mp_per <= cfg_period; mp_duty <= cfg_duty;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic running;
        running = rst && m_gen;
        chk("m_cnt_en",  cnt_en,      running);
        chk("m_cnt_clr", cnt_clr,     running ? (count == m_per) : 1'b1);
        chk("m_pd",      period_done, running ? (count == m_per) : 1'b0);
        chk("m_pwm",     pwm_out,     running ? (count < m_duty) : 1'b0);
        chk("m_ready",   cfg_ready,   !mp_v);
    end

    task automatic transfer(input logic [7:0] p, input logic [7:0] d);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_period = p; cfg_duty = d;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_count(input logic [7:0] v);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(count == v && cnt_en) && n < 200);
        chk("wait_count", (count == v && cnt_en), 1);
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        do begin @(negedge clk); waited++; end while (!cfg_ready && waited < 200);
        chk("wait_ready", cfg_ready, 1);
    endtask

    // Samples the current negedge plus n-1 following ones.
    task automatic measure(input int n, output int highs, output int pds, output logic last_pd);
        highs = 0; pds = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            highs += int'(pwm_out);
            pds   += int'(period_done);
            last_pd = period_done;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int h, p, w, n, clrs;
        logic lp;
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = 8'd0; cfg_duty = 8'd0;
        #2;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_clr", cnt_clr, 1);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pd", period_done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // en without any configuration stays idle
        en = 1'b1;
        repeat (4) begin @(negedge clk); chk("idle_no_cfg", cnt_en, 0); end

        // 9/3 with en already high: capture, load, then run
        transfer(8'd9, 8'd3);
        w = 0;
        do begin @(negedge clk); w++; end while (!cnt_en && w < 50);
        chk("start_latency", w, 3);
        chk("start_count", count, 0);
        measure(10, h, p, lp);
        chk("p93_highs", h, 3); chk("p93_pds", p, 1); chk("p93_lastpd", lp, 1);
        @(negedge clk);
        measure(10, h, p, lp);
        chk("p93b_highs", h, 3); chk("p93b_pds", p, 1);

        // mid-period change to 4/2
        wait_count(8'd4);
        transfer(8'd4, 8'd2);
        @(negedge clk);
        chk("busy_ready", cfg_ready, 0);
        wait_ready(w);
        chk("new_per_start", count, 0);
        measure(5, h, p, lp);
        chk("p42_highs", h, 2); chk("p42_pds", p, 1); chk("p42_lastpd", lp, 1);
        @(negedge clk);
        measure(5, h, p, lp);
        chk("p42b_highs", h, 2); chk("p42b_lastpd", lp, 1);

        // back to 9/3, then drop en at count 5
        transfer(8'd9, 8'd3);
        wait_ready(w);
        wait_count(8'd4);
        @(posedge clk); #1 en = 1'b0;
        n = 0; p = 0;
        do begin
            @(negedge clk);
            if (cnt_en) begin n++; p += int'(period_done); end
        end while (cnt_en && n < 20);
        chk("drain_cycles", n, 5);
        chk("drain_pds", p, 1);
        chk("idle_clr", cnt_clr, 1);
        chk("idle_pwm", pwm_out, 0);

        // restart, go to drain at count 6, re-request run there
        @(posedge clk); #1 en = 1'b1;
        wait_count(8'd4);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        n = 0; clrs = 0;
        do begin
            @(negedge clk); n++; clrs += int'(cnt_clr);
        end while (!period_done && n < 20);
        chk("resume_cycles", n, 4);
        chk("resume_clrs", clrs, 1);
        @(negedge clk);
        chk("resume_run", cnt_en, 1);
        chk("resume_wrap", count, 0);

        // transfer on a boundary cycle lands in pending, loads a period later
        wait_count(8'd8);
        transfer(8'd9, 8'd5);
        wait_ready(w);
        chk("bnd_xfer_wait", w, 11);
        measure(10, h, p, lp);
        chk("p95_highs", h, 5);

        // duty edge cases
        transfer(8'd9, 8'd0);
        wait_ready(w);
        measure(10, h, p, lp);
        chk("duty0_highs", h, 0); chk("duty0_pds", p, 1);
        transfer(8'd9, 8'd12);
        wait_ready(w);
        measure(10, h, p, lp);
        chk("duty12_highs", h, 10); chk("duty12_pds", p, 1);
        transfer(8'd0, 8'd1);
        wait_ready(w);
        measure(4, h, p, lp);
        chk("per0_pds", p, 4); chk("per0_highs", h, 4);

        // foreign counter value above per_a is not a boundary
        transfer(8'd9, 8'd3);
        wait_ready(w);
        wait_count(8'd2);
        @(posedge clk); #1 force_on = 1'b1; force_val = 8'd200;
        repeat (3) begin
            @(negedge clk);
            chk("foreign_clr", cnt_clr, 0);
            chk("foreign_pd", period_done, 0);
        end
        @(posedge clk); #1 force_on = 1'b0;

        // reset between edges at count 2
        wait_count(8'd1);
        @(posedge clk); #3;
        chk("pre_rst_pwm", pwm_out, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt_en", cnt_en, 0);
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_clr", cnt_clr, 1);
        chk("mid_rst_ready", cfg_ready, 1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) begin @(negedge clk); chk("post_rst_idle", cnt_en, 0); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
